context_switch_unit: RTL and testbench

- Per-process PC context table and switch sequencer that sits directly downstream of the round-robin scheduler.
- On a scheduler switch request it:
  - saves the interrupted process's PC into that process's slot;
  - fetches the incoming process's saved PC;
  - stalls the CPU while the sequence runs;
  - issues a one-cycle PC-load pulse to the fetch stage.
- Also maintains process creation and kill state as an active mask.

---
 rtl/context_switch_unit.sv | 146 ++++++++++++++
 tb/tb_context_switch_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/context_switch_unit.sv
// Per-process PC context table plus the save/load/resume sequencer that turns a
// scheduler switch request into a stalled, single-pulse PC reload of the CPU.
module context_switch_unit #(
  parameter int NUM_PROCS = 8,
  parameter int PID_W     = 3,
  parameter int PC_W      = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 switch_req,
  input  logic [PC_W-1:0]      cur_pc,
  input  logic [PID_W-1:0]     next_pid,
  input  logic                 create_valid,
  input  logic [PID_W-1:0]     create_pid,
  input  logic [PC_W-1:0]      create_pc,
  input  logic                 kill_valid,
  input  logic [PID_W-1:0]     kill_pid,
  output logic                 stall_cpu,
  output logic                 pc_load,
  output logic [PC_W-1:0]      pc_out,
  output logic [PID_W-1:0]     running_pid,
  output logic [NUM_PROCS-1:0] active_mask,
  output logic                 busy,
  output logic                 switch_err,
  output logic                 switch_overrun
);

  typedef enum logic [1:0] {IDLE, SAVE, LOAD, RESUME} state_t;

  state_t               state_reg, state_next;
  logic [PC_W-1:0]      sv_pc_reg;
  logic [PID_W-1:0]     tgt_reg;
  logic [PID_W-1:0]     running_pid_reg;
  logic [PC_W-1:0]      pc_out_reg;
  logic                 pc_load_reg;
  logic                 switch_err_reg;
  logic                 overrun_reg;
  logic [NUM_PROCS-1:0] active_reg;
  logic [PC_W-1:0]      pc_table [NUM_PROCS];

  logic busy_w, start_w, save_we, load_en, resume_en, tgt_live;
  logic [PID_W-1:0] create_slot, kill_slot, next_slot;

  // Out-of-range PIDs alias onto a real slot.
  function automatic logic [PID_W-1:0] slot_of(input logic [PID_W-1:0] pid);
    return PID_W'(pid % NUM_PROCS);
  endfunction

  assign create_slot = slot_of(create_pid);
  assign kill_slot   = slot_of(kill_pid);
  assign next_slot   = slot_of(next_pid);
  assign tgt_live    = active_reg[tgt_reg];

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_w) state_next = SAVE;
      SAVE:    state_next = LOAD;
      LOAD:    state_next = RESUME;
      RESUME:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs; the pc_load cycle after RESUME still counts as busy.
  always_comb begin
    busy_w    = (state_reg != IDLE) || pc_load_reg;
    start_w   = switch_req && !busy_w;
    save_we   = (state_reg == SAVE) && active_reg[running_pid_reg];
    load_en   = (state_reg == LOAD);
    resume_en = (state_reg == RESUME);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sv_pc_reg       <= '0;
      tgt_reg         <= '0;
      running_pid_reg <= '0;
      pc_out_reg      <= '0;
      pc_load_reg     <= 1'b0;
      switch_err_reg  <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      if (start_w) begin
        sv_pc_reg <= cur_pc;
        tgt_reg   <= next_slot;
      end
      if (load_en) begin
        if (tgt_live) begin
          pc_out_reg      <= pc_table[tgt_reg];
          running_pid_reg <= tgt_reg;
        end else begin
          pc_out_reg <= sv_pc_reg;
        end
      end
      switch_err_reg <= load_en && !tgt_live;
      pc_load_reg    <= resume_en;
      if (switch_req && busy_w) overrun_reg <= 1'b1;
    end
  end

  // Create beats kill on the same slot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_PROCS; i++) begin
        if (create_valid && create_slot == PID_W'(i))
          active_reg[i] <= 1'b1;
        else if (kill_valid && kill_slot == PID_W'(i))
          active_reg[i] <= 1'b0;
      end
    end
  end

  // Table contents are don't-care while a slot is inactive, so no reset.
  generate
    for (genvar gi = 0; gi < NUM_PROCS; gi++) begin : gen_slot
      logic [PC_W-1:0] slot_pc_reg;
      always_ff @(posedge clock) begin
        if (create_valid && create_slot == PID_W'(gi))
          slot_pc_reg <= create_pc;
        else if (save_we && running_pid_reg == PID_W'(gi))
          slot_pc_reg <= sv_pc_reg;
      end
      assign pc_table[gi] = slot_pc_reg;
    end
  endgenerate

  assign stall_cpu      = busy_w;
  assign busy           = busy_w;
  assign pc_load        = pc_load_reg;
  assign pc_out         = pc_out_reg;
  assign running_pid    = running_pid_reg;
  assign active_mask    = active_reg;
  assign switch_err     = switch_err_reg;
  assign switch_overrun = overrun_reg;

endmodule

// File: tb/tb_context_switch_unit.sv
// Directed bench for context_switch_unit: switch sequencing, error/overrun
// flags, create/kill interactions and asynchronous reset mid-sequence.
module tb_context_switch_unit;

  localparam int NUM_PROCS = 8;
  localparam int PID_W     = 3;
  localparam int PC_W      = 32;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic                 switch_req = 1'b0;
  logic [PC_W-1:0]      cur_pc = '0;
  logic [PID_W-1:0]     next_pid = '0;
  logic                 create_valid = 1'b0;
  logic [PID_W-1:0]     create_pid = '0;
  logic [PC_W-1:0]      create_pc = '0;
  logic                 kill_valid = 1'b0;
  logic [PID_W-1:0]     kill_pid = '0;
  logic                 stall_cpu, pc_load, busy, switch_err, switch_overrun;
  logic [PC_W-1:0]      pc_out;
  logic [PID_W-1:0]     running_pid;
  logic [NUM_PROCS-1:0] active_mask;

  int vectors = 0;
  int miscompares = 0;

  // Results captured by run_switch / watch
  int               n_stall, n_load, load_cyc, n_err;
  logic [PC_W-1:0]  load_pc;
  logic [PID_W-1:0] load_pid;

  context_switch_unit #(.NUM_PROCS(NUM_PROCS), .PID_W(PID_W), .PC_W(PC_W)) dut (
    .clock(clock), .reset(reset), .switch_req(switch_req), .cur_pc(cur_pc),
    .next_pid(next_pid), .create_valid(create_valid), .create_pid(create_pid),
    .create_pc(create_pc), .kill_valid(kill_valid), .kill_pid(kill_pid),
    .stall_cpu(stall_cpu), .pc_load(pc_load), .pc_out(pc_out),
    .running_pid(running_pid), .active_mask(active_mask), .busy(busy),
    .switch_err(switch_err), .switch_overrun(switch_overrun)
  );

  always #5 clock = ~clock;

  // Observe n cycles from the current negedge, recording pulses.
  task automatic watch(input int n, input int first_cyc);
    for (int i = 0; i < n; i++) begin
      if (stall_cpu) n_stall++;
      if (switch_err) n_err++;
      if (pc_load) begin
        n_load++;
        load_cyc = first_cyc + i;
        load_pc  = pc_out;
        load_pid = running_pid;
      end
      @(negedge clock);
    end
  endtask

  task automatic clear_obs();
    n_stall = 0; n_load = 0; load_cyc = 0; n_err = 0; load_pc = '0; load_pid = '0;
  endtask

  // One-cycle switch request; cycle 1 is the cycle after the sampling edge.
  task automatic run_switch(input logic [PC_W-1:0] pc, input logic [PID_W-1:0] pid);
    clear_obs();
    @(negedge clock);
    switch_req = 1'b1; cur_pc = pc; next_pid = pid;
    @(negedge clock);
    switch_req = 1'b0;
    watch(6, 1);
  endtask

  task automatic do_create(input logic [PID_W-1:0] pid, input logic [PC_W-1:0] pc);
    @(negedge clock);
    create_valid = 1'b1; create_pid = pid; create_pc = pc;
    @(negedge clock);
    create_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    vectors++;
    if ({stall_cpu, pc_load, pc_out, running_pid, active_mask, busy, switch_err, switch_overrun} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got stall=%b load=%b pc=%h pid=%0d mask=%h busy=%b err=%b ovr=%b, want all 0",
               stall_cpu, pc_load, pc_out, running_pid, active_mask, busy, switch_err, switch_overrun);
    end
    @(negedge clock);
    reset = 1'b0;
    do_create(3'd0, 32'h100);
    do_create(3'd1, 32'h200);
    vectors++;
    if (active_mask !== 8'h03 || stall_cpu !== 1'b0 || pc_load !== 1'b0 || pc_out !== '0 ||
        running_pid !== '0 || busy !== 1'b0 || switch_err !== 1'b0 || switch_overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL after_create: got mask=%h stall=%b load=%b pc=%h pid=%0d, want mask=03 rest 0",
               active_mask, stall_cpu, pc_load, pc_out, running_pid);
    end
    $display("test_reset: mask=%h", active_mask);
  endtask

  task automatic test_switch();
    run_switch(32'h140, 3'd1);
    vectors++;
    if (n_stall !== 4 || n_load !== 1 || load_cyc !== 4) begin
      miscompares++;
      $display("FAIL switch_timing: got stall=%0d loads=%0d load_cyc=%0d, want 4/1/4", n_stall, n_load, load_cyc);
    end
    vectors++;
    if (load_pc !== 32'h200 || load_pid !== 3'd1 || n_err !== 0) begin
      miscompares++;
      $display("FAIL switch_0to1: got pc=%h pid=%0d err=%0d, want 200/1/0", load_pc, load_pid, n_err);
    end
    $display("switch 0->1: pc=%h pid=%0d", load_pc, load_pid);
    run_switch(32'h230, 3'd0);
    vectors++;
    if (load_pc !== 32'h140 || load_pid !== 3'd0 || n_load !== 1) begin
      miscompares++;
      $display("FAIL switch_1to0: got pc=%h pid=%0d loads=%0d, want 140/0/1", load_pc, load_pid, n_load);
    end
    $display("switch 1->0: pc=%h pid=%0d", load_pc, load_pid);
    run_switch(32'h150, 3'd1);
    vectors++;
    if (load_pc !== 32'h230 || load_pid !== 3'd1) begin
      miscompares++;
      $display("FAIL saved_pc1: got pc=%h pid=%0d, want 230/1", load_pc, load_pid);
    end
    $display("switch 0->1: pc=%h pid=%0d", load_pc, load_pid);
    vectors++;
    if (stall_cpu !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after: got stall=%b busy=%b, want 0/0", stall_cpu, busy);
    end
  endtask

  task automatic test_inactive_target();
    run_switch(32'h250, 3'd5);
    vectors++;
    if (n_err !== 1 || load_pc !== 32'h250 || load_pid !== 3'd1 || n_load !== 1) begin
      miscompares++;
      $display("FAIL inactive_tgt: got err=%0d pc=%h pid=%0d loads=%0d, want 1/250/1/1",
               n_err, load_pc, load_pid, n_load);
    end
    $display("switch 1->5(inactive): err=%0d pc=%h pid=%0d", n_err, load_pc, load_pid);
  endtask

  task automatic test_self_switch();
    run_switch(32'h260, 3'd1);
    vectors++;
    if (load_pc !== 32'h260 || load_pid !== 3'd1 || n_err !== 0 || n_stall !== 4) begin
      miscompares++;
      $display("FAIL self_switch: got pc=%h pid=%0d err=%0d stall=%0d, want 260/1/0/4",
               load_pc, load_pid, n_err, n_stall);
    end
    $display("switch 1->1: pc=%h", load_pc);
  endtask

  task automatic test_overrun();
    vectors++;
    if (switch_overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_pre: got %b, want 0", switch_overrun);
    end
    clear_obs();
    @(negedge clock);
    switch_req = 1'b1; cur_pc = 32'h270; next_pid = 3'd0;
    @(negedge clock);
    cur_pc = 32'h999; next_pid = 3'd1;   // second request lands in SAVE
    watch(1, 1);
    switch_req = 1'b0;
    watch(7, 2);
    vectors++;
    if (switch_overrun !== 1'b1 || n_load !== 1 || load_pc !== 32'h150 || load_pid !== 3'd0) begin
      miscompares++;
      $display("FAIL overrun: got ovr=%b loads=%0d pc=%h pid=%0d, want 1/1/150/0",
               switch_overrun, n_load, load_pc, load_pid);
    end
    $display("overrun switch 1->0: ovr=%b loads=%0d pc=%h", switch_overrun, n_load, load_pc);
  endtask

  task automatic test_kill_running();
    @(negedge clock);
    kill_valid = 1'b1; kill_pid = 3'd0;
    @(negedge clock);
    kill_valid = 1'b0;
    vectors++;
    if (active_mask !== 8'h02 || running_pid !== 3'd0) begin
      miscompares++;
      $display("FAIL kill_running: got mask=%h pid=%0d, want 02/0", active_mask, running_pid);
    end
    run_switch(32'h333, 3'd1);
    vectors++;
    if (load_pc !== 32'h270 || load_pid !== 3'd1 || n_err !== 0) begin
      miscompares++;
      $display("FAIL resume_after_kill: got pc=%h pid=%0d err=%0d, want 270/1/0", load_pc, load_pid, n_err);
    end
    $display("switch killed0->1: pc=%h pid=%0d", load_pc, load_pid);
    @(negedge clock);
    create_valid = 1'b1; create_pid = 3'd2; create_pc = 32'h400;
    kill_valid = 1'b1; kill_pid = 3'd2;
    @(negedge clock);
    create_valid = 1'b0; kill_valid = 1'b0;
    vectors++;
    if (active_mask !== 8'h06) begin
      miscompares++;
      $display("FAIL create_kill_same: got mask=%h, want 06", active_mask);
    end
    run_switch(32'h444, 3'd2);
    vectors++;
    if (load_pc !== 32'h400 || load_pid !== 3'd2) begin
      miscompares++;
      $display("FAIL switch_to_2: got pc=%h pid=%0d, want 400/2", load_pc, load_pid);
    end
    $display("switch 1->2: pc=%h pid=%0d", load_pc, load_pid);
  endtask

  task automatic test_create_collision();
    // Self-switch on pid2 with a create of pid2 in the SAVE cycle: create wins.
    clear_obs();
    @(negedge clock);
    switch_req = 1'b1; cur_pc = 32'h500; next_pid = 3'd2;
    @(negedge clock);
    switch_req = 1'b0;
    create_valid = 1'b1; create_pid = 3'd2; create_pc = 32'h600;
    watch(1, 1);
    create_valid = 1'b0;
    watch(6, 2);
    vectors++;
    if (load_pc !== 32'h600 || load_pid !== 3'd2 || n_load !== 1) begin
      miscompares++;
      $display("FAIL create_vs_save: got pc=%h pid=%0d loads=%0d, want 600/2/1", load_pc, load_pid, n_load);
    end
    $display("create-vs-save pid2: pc=%h", load_pc);
    // Switch to inactive pid3 while creating it in the SAVE cycle.
    clear_obs();
    @(negedge clock);
    switch_req = 1'b1; cur_pc = 32'h610; next_pid = 3'd3;
    @(negedge clock);
    switch_req = 1'b0;
    create_valid = 1'b1; create_pid = 3'd3; create_pc = 32'h300;
    watch(1, 1);
    create_valid = 1'b0;
    watch(6, 2);
    vectors++;
    if (load_pc !== 32'h300 || load_pid !== 3'd3 || n_err !== 0) begin
      miscompares++;
      $display("FAIL create_before_load: got pc=%h pid=%0d err=%0d, want 300/3/0", load_pc, load_pid, n_err);
    end
    $display("create-before-load pid3: pc=%h pid=%0d", load_pc, load_pid);
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    switch_req = 1'b1; cur_pc = 32'h620; next_pid = 3'd1;
    @(negedge clock);
    switch_req = 1'b0;
    @(negedge clock);                    // state LOAD
    reset = 1'b1;
    #1;
    vectors++;
    if ({stall_cpu, pc_load, pc_out, running_pid, active_mask, busy, switch_err, switch_overrun} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: got stall=%b load=%b pc=%h pid=%0d mask=%h busy=%b err=%b ovr=%b, want all 0",
               stall_cpu, pc_load, pc_out, running_pid, active_mask, busy, switch_err, switch_overrun);
    end
    @(negedge clock);
    vectors++;
    if (pc_load !== 1'b0 || stall_cpu !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: got load=%b stall=%b, want 0/0", pc_load, stall_cpu);
    end
    reset = 1'b0;
    do_create(3'd0, 32'h700);
    do_create(3'd4, 32'h800);
    run_switch(32'h710, 3'd4);
    vectors++;
    if (load_pc !== 32'h800 || load_pid !== 3'd4 || n_stall !== 4 || n_load !== 1 || load_cyc !== 4) begin
      miscompares++;
      $display("FAIL post_reset_switch: got pc=%h pid=%0d stall=%0d loads=%0d cyc=%0d, want 800/4/4/1/4",
               load_pc, load_pid, n_stall, n_load, load_cyc);
    end
    $display("post-reset switch 0->4: pc=%h pid=%0d", load_pc, load_pid);
    run_switch(32'h810, 3'd0);
    vectors++;
    if (load_pc !== 32'h710 || load_pid !== 3'd0) begin
      miscompares++;
      $display("FAIL post_reset_back: got pc=%h pid=%0d, want 710/0", load_pc, load_pid);
    end
    $display("post-reset switch 4->0: pc=%h pid=%0d", load_pc, load_pid);
  endtask

  initial begin
    test_reset();
    test_switch();
    test_inactive_target();
    test_self_switch();
    test_overrun();
    test_kill_running();
    test_create_collision();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
